// File: rtl/tone_oscillator_pkg.sv
// Shared audio definitions used by the note/octave divider lookup and by the
// tone oscillator that turns the looked-up period into a square wave.
package tone_oscillator_pkg;

  // Width of a period divider, in clock cycles per audio period.
  localparam int DIV_W = 19;

  // A period divider value as passed from the lookup stage downstream.
  typedef logic [DIV_W-1:0] div_t;

  // Divider code the lookup emits for a silent (rest) note.
  localparam div_t DIV_OFF = 19'd1;

  // Shortest period that still produces a sounding tone.
  localparam int DIV_MIN = 2;

  // Operating condition of the oscillator on a given cycle. IDLE means no
  // usable period is latched, WRAP is the last cycle of a running period,
  // DISABLED is the forced-silent condition while enable is low.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_WRAP     = 2'd2,
    ST_DISABLED = 2'd3
  } osc_state_e;

endpackage

// File: rtl/tone_oscillator.sv
// Square-wave tone generator. A latched period divider drives a phase counter;
// the output is high for the first floor(P/2) cycles of each P-cycle period.
// New divider values are only picked up at period boundaries so that note
// changes never glitch the waveform.
module tone_oscillator #(
  parameter int DIV_W = 19
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             enable,
  input  logic [DIV_W-1:0] div_in,
  output logic             square_out,
  output logic             period_tick,
  output logic             active
);

  import tone_oscillator_pkg::*;

  localparam logic [DIV_W-1:0] MIN_PERIOD = DIV_W'(DIV_MIN);
  localparam logic [DIV_W-1:0] ONE        = DIV_W'(1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic [DIV_W-1:0] count_q;
  logic [DIV_W-1:0] count_d;
  logic [DIV_W-1:0] half;
  logic [DIV_W-1:0] count_inc;
  logic             square_q;
  logic             square_d;
  logic             tick_q;
  logic             tick_d;
  logic             load_audible;
  osc_state_e       state;

  // Half the latched period sets the length of the high phase; the counter
  // never passes div_q-1, so the increment below cannot overflow.
  assign half         = div_q >> 1;
  assign count_inc    = count_q + ONE;
  assign load_audible = (div_in >= MIN_PERIOD);

  // Classify the current cycle from the registered period and phase. Enable
  // has top priority, then an unusable latched period, then the wrap point.
  always_comb begin
    state = ST_RUN;
    if (!enable) begin
      state = ST_DISABLED;
    end else if (div_q < MIN_PERIOD) begin
      state = ST_IDLE;
    end else if (count_q == (div_q - ONE)) begin
      state = ST_WRAP;
    end
  end

  // Next-state logic. The divider is sampled only when idle or at a wrap, so a
  // period in progress always completes with the value it started with. The
  // first cycle of every period (count 0) is driven high when the new period
  // is audible, which is also where the wrap pulse lands.
  always_comb begin
    div_d    = div_q;
    count_d  = count_q;
    square_d = square_q;
    tick_d   = 1'b0;
    unique case (state)
      ST_DISABLED: begin
        div_d    = '0;
        count_d  = '0;
        square_d = 1'b0;
      end
      ST_IDLE: begin
        div_d    = div_in;
        count_d  = '0;
        square_d = load_audible;
      end
      ST_WRAP: begin
        div_d    = div_in;
        count_d  = '0;
        square_d = load_audible;
        tick_d   = 1'b1;
      end
      ST_RUN: begin
        count_d  = count_inc;
        square_d = (count_inc < half);
      end
      default: begin
        div_d    = '0;
        count_d  = '0;
        square_d = 1'b0;
      end
    endcase
  end

  // State register. Reset clears everything immediately, even mid-period, so
  // the oscillator always restarts from a clean idle condition.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      div_q    <= '0;
      count_q  <= '0;
      square_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      div_q    <= div_d;
      count_q  <= count_d;
      square_q <= square_d;
      tick_q   <= tick_d;
    end
  end

  // Outputs come straight from flops, with the tone indicator decoded from
  // the latched period so it changes exactly when a new period is taken.
  assign square_out  = square_q;
  assign period_tick = tick_q;
  assign active      = (div_q >= MIN_PERIOD);

endmodule

// File: tb/tb_tone_oscillator.sv
// Self-checking bench for tone_oscillator: directed waveform scenarios with
// closed-form expectations plus a randomized run against a phase model.
module tb_tone_oscillator;

  import tone_oscillator_pkg::*;

  localparam int W = 19;

  logic         clk;
  logic         n_rst;
  logic         enable;
  logic [W-1:0] div_in;
  logic         square_out;
  logic         period_tick;
  logic         active;

  int checks;
  int errors;

  // Reference model: the latched period in cycles (0 when nothing sounds),
  // the position within that period, and whether this cycle starts a new
  // period that followed a completed one.
  int mPeriod;
  int mPos;
  bit mTick;

  tone_oscillator #(.DIV_W(W)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .enable      (enable),
    .div_in      (div_in),
    .square_out  (square_out),
    .period_tick (period_tick),
    .active      (active)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model expectations derived from the waveform rules: a sounding period P
  // is high for its first P/2 cycles.
  function automatic bit expSquare();
    return (mPeriod >= 2) && (mPos < (mPeriod / 2));
  endfunction

  function automatic bit expActive();
    return (mPeriod >= 2);
  endfunction

  // Advance one clock, updating the model at the edge, then return on the
  // falling edge where outputs are sampled and inputs are changed.
  task automatic tick_clk();
    @(posedge clk);
    if (n_rst) begin
      if (!enable) begin
        mPeriod = 0;
        mPos    = 0;
        mTick   = 0;
      end else if (mPeriod < 2) begin
        mPeriod = int'(div_in);
        mPos    = 0;
        mTick   = 0;
      end else if (mPos == mPeriod - 1) begin
        mPeriod = int'(div_in);
        mPos    = 0;
        mTick   = 1;
      end else begin
        mPos  = mPos + 1;
        mTick = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    mPeriod = 0;
    mPos    = 0;
    mTick   = 0;
  endtask

  // Force the oscillator idle for one cycle, then start a fresh period p.
  task automatic restart(input int p);
    enable = 1'b0;
    tick_clk();
    enable = 1'b1;
    div_in = W'(p);
    tick_clk();
  endtask

  task automatic test_reset();
    n_rst  = 1'b0;
    enable = 1'b1;
    div_in = W'(10);
    model_reset();
    #3;
    checks++;
    if (square_out !== 1'b0 || period_tick !== 1'b0 || active !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: sq=%b tick=%b act=%b, required 0 0 0",
               square_out, period_tick, active);
    end
    @(negedge clk);
    tick_clk();
    checks++;
    if (square_out !== 1'b0 || active !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_hold: sq=%b act=%b, required 0 0",
               square_out, active);
    end
  endtask

  // Release reset with div 10 and check the steady 5 high / 5 low waveform.
  task automatic test_release10(input string name);
    bit eSq;
    bit eTk;
    enable = 1'b1;
    div_in = W'(10);
    n_rst  = 1'b1;
    tick_clk();
    for (int k = 0; k < 30; k++) begin
      eSq = ((k % 10) < 5);
      eTk = ((k % 10) == 0) && (k > 0);
      checks++;
      if (square_out !== eSq || period_tick !== eTk || active !== 1'b1) begin
        errors++;
        $display("[TB] FAIL %s k=%0d: sq=%b tick=%b act=%b, required %b %b 1",
                 name, k, square_out, period_tick, active, eSq, eTk);
      end
      tick_clk();
    end
  endtask

  // Fresh period p: high for p/2 cycles, low for the rest, tick each wrap.
  task automatic test_period(input int p, input string name);
    bit eSq;
    bit eTk;
    restart(p);
    for (int k = 0; k < 4 * p; k++) begin
      eSq = ((k % p) < (p / 2));
      eTk = ((k % p) == 0) && (k > 0);
      checks++;
      if (square_out !== eSq || period_tick !== eTk || active !== 1'b1) begin
        errors++;
        $display("[TB] FAIL %s k=%0d: sq=%b tick=%b act=%b, required %b %b 1",
                 name, k, square_out, period_tick, active, eSq, eTk);
      end
      tick_clk();
    end
  endtask

  // Divider changes 10 -> 6 at count 3; the running period must complete.
  task automatic test_change_mid();
    bit eSq;
    bit eTk;
    restart(10);
    for (int k = 0; k < 28; k++) begin
      if (k == 3) div_in = W'(6);
      eSq = (k < 10) ? (k < 5) : (((k - 10) % 6) < 3);
      eTk = (k == 10) || (k == 16) || (k == 22);
      checks++;
      if (square_out !== eSq || period_tick !== eTk) begin
        errors++;
        $display("[TB] FAIL change_mid k=%0d: sq=%b tick=%b, required %b %b",
                 k, square_out, period_tick, eSq, eTk);
      end
      tick_clk();
    end
  endtask

  // Divider set to the off code mid-period: silence starts at the wrap.
  task automatic test_off_mid();
    bit eSq;
    bit eTk;
    bit eAct;
    restart(10);
    for (int k = 0; k < 18; k++) begin
      if (k == 4) div_in = DIV_OFF;
      eSq  = (k < 5);
      eTk  = (k == 10);
      eAct = (k < 10);
      checks++;
      if (square_out !== eSq || period_tick !== eTk || active !== eAct) begin
        errors++;
        $display("[TB] FAIL off_mid k=%0d: sq=%b tick=%b act=%b, required %b %b %b",
                 k, square_out, period_tick, active, eSq, eTk, eAct);
      end
      tick_clk();
    end
  endtask

  // Enable dropped while high, then re-enabled with div 8.
  task automatic test_enable_drop();
    bit eSq;
    restart(10);
    tick_clk();
    tick_clk();
    enable = 1'b0;
    tick_clk();
    checks++;
    if (square_out !== 1'b0 || active !== 1'b0 || period_tick !== 1'b0) begin
      errors++;
      $display("[TB] FAIL enable_drop: sq=%b act=%b tick=%b, required 0 0 0",
               square_out, active, period_tick);
    end
    enable = 1'b1;
    div_in = W'(8);
    tick_clk();
    for (int k = 0; k < 24; k++) begin
      eSq = ((k % 8) < 4);
      checks++;
      if (square_out !== eSq || active !== 1'b1) begin
        errors++;
        $display("[TB] FAIL reenable k=%0d: sq=%b act=%b, required %b 1",
                 k, square_out, active, eSq);
      end
      tick_clk();
    end
  endtask

  // Reset asserted between edges while running; outputs clear at once.
  task automatic test_async_reset();
    restart(10);
    tick_clk();
    tick_clk();
    #2;
    n_rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (square_out !== 1'b0 || period_tick !== 1'b0 || active !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: sq=%b tick=%b act=%b, required 0 0 0",
               square_out, period_tick, active);
    end
    @(negedge clk);
    test_release10("after_async_reset");
  endtask

  // Random divider and enable traffic compared every cycle against the model.
  task automatic test_random();
    int r;
    int c;
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      enable = (r >= 2);
      if ($urandom_range(0, 7) == 0) begin
        c = $urandom_range(0, 11);
        case (c)
          0:       div_in = '0;
          1:       div_in = DIV_OFF;
          2:       div_in = W'(2);
          3:       div_in = W'(3);
          4:       div_in = '1;
          default: div_in = W'($urandom_range(4, 40));
        endcase
      end
      tick_clk();
      checks++;
      if (square_out !== expSquare() || period_tick !== mTick ||
          active !== expActive()) begin
        errors++;
        $display("[TB] FAIL random n=%0d: sq=%b tick=%b act=%b, required %b %b %b (P=%0d pos=%0d)",
                 n, square_out, period_tick, active, expSquare(), mTick,
                 expActive(), mPeriod, mPos);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_release10("release10");
    test_period(7, "period7");
    test_period(2, "period2");
    test_period(3, "period3");
    test_change_mid();
    test_off_mid();
    test_enable_drop();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/tone_oscillator.md
Name: tone_oscillator

Overview:
- Downstream consumer of the note/octave divider lookup. Takes the 19-bit period divider (clock cycles per audio period) and generates a 50%-nominal square wave for the audio output stage.
- Divider changes take effect only at period boundaries, so note changes never cause phase glitches or runt pulses.
- Divider values below 2 (the lookup's "off" code 1, or 0) silence the output.

Parameters:
- DIV_W, 19, width of divider input and internal period counter.

Ports:
- clk  input  1  system clock (10/12 MHz).
- n_rst  input  1  asynchronous, active-low reset.
- enable  input  1  1 = oscillator runs; 0 = forced silent and idle.
- div_in  input  DIV_W  requested period in clk cycles, from lookup stage; sampled only at load points.
- square_out  output  1  registered square wave.
- period_tick  output  1  one-cycle pulse on the cycle the counter wraps.
- active  output  1  high when the latched period is ≥ 2 (tone sounding).

Behaviour:
- Registers:
  - div_q[DIV_W-1:0] holds the latched period.
  - count[DIV_W-1:0] holds the phase.
  - square_out and period_tick are flops.
  - half = div_q >> 1.
  - active = (div_q >= 2), decoded from registers.
- Reset (async, n_rst low): div_q=0, count=0, square_out=0, period_tick=0, so active=0. Reset takes effect immediately, mid-period included; no state is retained.
- Per posedge with n_rst high, evaluated in priority order:
  1. enable=0 → div_q<=0, count<=0, square_out<=0, period_tick<=0.
  2. IDLE (div_q<2) → div_q<=div_in, count<=0, square_out<=(div_in>=2), period_tick<=0. This gives 1-cycle start latency.
  3. WRAP (count==div_q-1) → count<=0, div_q<=div_in, square_out<=(div_in>=2), period_tick<=1.
  4. RUN otherwise → count<=count+1, square_out<=((count+1) < half), period_tick<=0.
- Resulting waveform for period P≥2: high for floor(P/2) cycles, low for ceil(P/2) cycles. Total period is exactly P cycles. The first high cycle is the one where count=0.
- div_in changes mid-period are ignored until WRAP; the current period always completes. No pending register is required because div_in is re-sampled at WRAP.
- div_in<2 at WRAP → next state is IDLE with square_out=0. div_in≥2 while IDLE loads on the next edge.
- Dropping enable silences the output on the next edge. Re-enabling passes through IDLE, so the first output cycle is always high with count=0.
- P=2 gives 1 high, 1 low, with period_tick every 2 cycles.
- Maximum P = 2^DIV_W−1. count never exceeds div_q−1, and the +1 cannot overflow.
- State summary: IDLE (div_q<2), RUN, WRAP (RUN sub-case). Enable low forces IDLE.

Decomposition:
- Shared audio package holds:
  - DIV_W=19.
  - DIV_OFF=19'd1, the "off" divider code.
  - DIV_MIN=2, the minimum audible period.
  - typedef div_t = logic [DIV_W-1:0], used by both the lookup stage and this block.
- No sub-module; a single always_ff plus decode logic.

Test Plan:
- Reset release with enable=1, div_in=10 → first edge loads; square_out then shows 5 high / 5 low repeating; period_tick pulses every 10 cycles, coincident with the first high cycle.
- div_in=7 → 3 high / 4 low, period 7; div_in=2 → alternating 1/0 with period_tick every 2 cycles.
- div_in changes 10→6 at count=3 → current period completes all 10 cycles; the next period is 3 high / 3 low; no runt pulse.
- div_in=10 running, div_in set to 1 mid-period → period completes; at WRAP square_out=0 and active=0; square_out stays 0 thereafter.
- enable deasserted at count=2 while high → square_out=0 on the next edge. Re-enable with div_in=8 → one IDLE cycle, then 4 high / 4 low starting at count=0.
- n_rst asserted asynchronously mid-period (between edges) → all outputs 0 immediately. On release, behaviour matches the first scenario.
